// File: rtl/othello_pkg.sv
// Shared Othello board encodings, colours and screen geometry.
package othello_pkg;

  localparam int BOARD_DIM  = 8;
  localparam int CELL_PX    = 12;
  localparam int CELL_PITCH = 13;
  localparam int BOARD_X0   = 9;
  localparam int BOARD_Y0   = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SIDE0 = 2'b10;
  localparam logic [1:0] CELL_SIDE1 = 2'b11;

  localparam logic [2:0] COL_EMPTY  = 3'b010;
  localparam logic [2:0] COL_SIDE0  = 3'b000;
  localparam logic [2:0] COL_SIDE1  = 3'b111;
  localparam logic [2:0] COL_CURSOR = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAW, ST_DONE} draw_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // 2'b01 is treated as empty along with CELL_EMPTY.
  function automatic logic [2:0] cell_colour(input logic [1:0] c);
    case (c)
      CELL_SIDE0: cell_colour = COL_SIDE0;
      CELL_SIDE1: cell_colour = COL_SIDE1;
      default:    cell_colour = COL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/board_drawer_square_scan.sv
// Row-major 2-D pixel counter over one SIZE x SIZE square.
module square_scan #(
  parameter  int SIZE = 12,
  localparam int W    = $clog2(SIZE)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear_i,
  input  logic         adv_i,
  output logic [W-1:0] px_o,
  output logic [W-1:0] py_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  logic [W-1:0] px_q, py_q;

  always_ff @(posedge clock) begin
    if (!resetn || clear_i) begin
      px_q <= '0;
      py_q <= '0;
    end else if (adv_i) begin
      if (px_q == LAST) begin
        px_q <= '0;
        py_q <= (py_q == LAST) ? '0 : py_q + 1'b1;
      end else begin
        px_q <= px_q + 1'b1;
      end
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign last_o = (px_q == LAST) && (py_q == LAST);

endmodule

// File: rtl/board_drawer.sv
// Start/done-handshaked full-board redraw: one LOAD cycle per cell, then
// CELL_SIZE^2 registered pixel writes, with an optional latched cursor ring.
module board_drawer
  import othello_pkg::*;
#(
  parameter int CELL_SIZE = CELL_PX,
  parameter int PITCH     = CELL_PITCH,
  parameter int X_ORIGIN  = BOARD_X0,
  parameter int Y_ORIGIN  = BOARD_Y0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       cursor_en,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  output logic [2:0] cell_x,
  output logic [2:0] cell_y,
  input  logic [1:0] cell_q,
  output logic [7:0] x_plot,
  output logic [6:0] y_plot,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int SW = $clog2(CELL_SIZE);
  localparam logic [SW-1:0] EDGE = SW'(CELL_SIZE - 1);
  localparam logic [2:0]    LAST_CELL = 3'(BOARD_DIM - 1);

  draw_state_e state_q;
  logic [2:0]  cx_q, cy_q;
  logic [1:0]  cell_state_q;
  logic        cur_en_q;
  logic [2:0]  cur_x_q, cur_y_q;
  logic        plot_q, done_q;
  pixel_t      pix_q, pix_d;

  logic [SW-1:0] px, py;
  logic          last, ring;

  square_scan #(.SIZE(CELL_SIZE)) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clear_i(state_q == ST_LOAD),
    .adv_i  (state_q == ST_DRAW),
    .px_o   (px),
    .py_o   (py),
    .last_o (last)
  );

  assign ring = (px == '0) || (px == EDGE) || (py == '0) || (py == EDGE);

  always_comb begin
    pix_d.x = 8'(X_ORIGIN + PITCH * int'(cx_q) + int'(px));
    pix_d.y = 7'(Y_ORIGIN + PITCH * int'(cy_q) + int'(py));
    if (cur_en_q && cx_q == cur_x_q && cy_q == cur_y_q && ring)
      pix_d.colour = COL_CURSOR;
    else
      pix_d.colour = cell_colour(cell_state_q);
  end

  // Pixel outputs lag the DRAW state by one register stage.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      cell_state_q <= '0;
      cur_en_q     <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      pix_q        <= '0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          cx_q     <= '0;
          cy_q     <= '0;
          cur_en_q <= cursor_en;
          cur_x_q  <= cursor_x;
          cur_y_q  <= cursor_y;
          state_q  <= ST_LOAD;
        end
        ST_LOAD: begin
          cell_state_q <= cell_q;
          state_q      <= ST_DRAW;
        end
        ST_DRAW: begin
          plot_q <= 1'b1;
          pix_q  <= pix_d;
          if (last) begin
            if (cx_q == LAST_CELL && cy_q == LAST_CELL) begin
              state_q <= ST_DONE;
            end else begin
              cx_q    <= cx_q + 1'b1;
              if (cx_q == LAST_CELL) cy_q <= cy_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cell_x = cx_q;
  assign cell_y = cy_q;
  assign x_plot = pix_q.x;
  assign y_plot = pix_q.y;
  assign colour = pix_q.colour;
  assign plot   = plot_q;
  assign done   = done_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_board_drawer.sv
// Scoreboarded bench for board_drawer: expected pixel stream queued at start,
// compared pixel-by-pixel as plots emerge, plus framebuffer spot checks.
module tb_board_drawer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       cursor_en = 1'b0;
  logic [2:0] cursor_x = '0, cursor_y = '0;
  logic [2:0] cell_x, cell_y;
  logic [1:0] cell_q;
  logic [7:0] x_plot;
  logic [6:0] y_plot;
  logic [2:0] colour;
  logic       plot, busy, done;

  logic [1:0] board  [8][8];   // [row][col]
  logic [1:0] mboard [8][8];   // board as the model expects each cell to be loaded
  logic [2:0] fb [160][120];

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t first_got, first_exp;
  int n_chk = 0, n_pass = 0;
  int plot_cnt, done_cnt, stream_err, coord_err;
  int lat, first_plot, busy_low;
  logic rst_plot, rst_busy;

  assign cell_q = board[cell_y][cell_x];

  always #5 clock = ~clock;

  board_drawer dut (
    .clock(clock), .resetn(resetn), .start(start), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cell_x(cell_x), .cell_y(cell_y),
    .cell_q(cell_q), .x_plot(x_plot), .y_plot(y_plot), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always @(negedge clock) begin
    int xi, yi;
    pix_t e, g;
    if (done) done_cnt++;
    if (plot) begin
      xi = int'(x_plot);
      yi = int'(y_plot);
      g  = {x_plot, y_plot, colour};
      plot_cnt++;
      if (xi < 160 && yi < 120) fb[xi][yi] = colour;
      if (xi < 9 || xi > 111 || yi < 9 || yi > 111 ||
          (xi - 9) % 13 == 12 || (yi - 9) % 13 == 12) coord_err++;
      if (exp_q.size() == 0) begin
        if (stream_err == 0) begin first_got = g; first_exp = '0; end
        stream_err++;
      end else begin
        e = exp_q.pop_front();
        if (e !== g) begin
          if (stream_err == 0) begin first_got = g; first_exp = e; end
          stream_err++;
        end
      end
    end
  end

  task automatic init_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) board[r][c] = 2'b00;
    board[3][3] = 2'b10; board[4][4] = 2'b10;
    board[3][4] = 2'b11; board[4][3] = 2'b11;
    mboard = board;
  endtask

  task automatic push_expected(input logic en, input int kx, input int ky);
    pix_t p;
    for (int cy = 0; cy < 8; cy++)
      for (int cx = 0; cx < 8; cx++)
        for (int py = 0; py < 12; py++)
          for (int px = 0; px < 12; px++) begin
            p.x = 8'(9 + 13 * cx + px);
            p.y = 7'(9 + 13 * cy + py);
            if (en && cx == kx && cy == ky && (px == 0 || px == 11 || py == 0 || py == 11))
              p.c = 3'b100;
            else if (mboard[cy][cx] == 2'b10) p.c = 3'b000;
            else if (mboard[cy][cx] == 2'b11) p.c = 3'b111;
            else p.c = 3'b010;
            exp_q.push_back(p);
          end
  endtask

  // Issues a start pulse, then watches up to 12000 cycles. Counting n from
  // the start edge; hooks fire at the negedge after edge n.
  task automatic run_draw(input int restart_at, input int move_at,
                          input int flip_at, input int rst_at);
    lat = -1; first_plot = -1; busy_low = 0;
    plot_cnt = 0; done_cnt = 0; stream_err = 0; coord_err = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) fb[x][y] = 3'b101;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int n = 1; n <= 12000; n++) begin
      @(posedge clock); @(negedge clock);
      if (n == rst_at) begin
        rst_plot = plot; rst_busy = busy; resetn = 1'b1;
        break;
      end
      if (plot && first_plot < 0) first_plot = n;
      if (done && lat < 0) lat = n;
      if (n <= 9280 && !busy) busy_low++;
      start = (n == restart_at);
      if (n == move_at) begin cursor_x = 3'd0; cursor_y = 3'd0; end
      if (n == flip_at) begin board[7][7] = 2'b11; board[0][0] = 2'b11; end
      if (n == rst_at - 1) resetn = 1'b0;
      if (lat >= 0 && n >= lat + 4) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_chk++; if ({plot, busy, done} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {plot, busy, done}); else n_pass++;
    n_chk++; if ({x_plot, y_plot, colour} !== 18'd0) $display("FAIL reset_pixel got %h want 0", {x_plot, y_plot, colour}); else n_pass++;
    n_chk++; if ({cell_x, cell_y} !== 6'd0) $display("FAIL reset_cell got %h want 0", {cell_x, cell_y}); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_initial_board();
    init_board();
    exp_q.delete();
    push_expected(1'b0, 0, 0);
    run_draw(0, 0, 0, 0);
    n_chk++; if (plot_cnt !== 9216) $display("FAIL init_plot_count got %0d want 9216", plot_cnt); else n_pass++;
    n_chk++; if (lat !== 9281) $display("FAIL init_done_latency got %0d want 9281", lat); else n_pass++;
    n_chk++; if (first_plot !== 2) $display("FAIL init_first_plot got %0d want 2", first_plot); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL init_done_count got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (busy_low !== 0) $display("FAIL init_busy_low got %0d want 0", busy_low); else n_pass++;
    n_chk++; if (fb[48][48] !== 3'b000) $display("FAIL pix_48_48 got %b want 000", fb[48][48]); else n_pass++;
    n_chk++; if (fb[61][48] !== 3'b111) $display("FAIL pix_61_48 got %b want 111", fb[61][48]); else n_pass++;
    n_chk++; if (fb[9][9] !== 3'b010) $display("FAIL pix_9_9 got %b want 010", fb[9][9]); else n_pass++;
    n_chk++; if (stream_err !== 0 || exp_q.size() != 0)
      $display("FAIL init_stream errs %0d left %0d got %h want %h", stream_err, exp_q.size(), first_got, first_exp); else n_pass++;
    n_chk++; if (coord_err !== 0) $display("FAIL init_coord_range got %0d want 0", coord_err); else n_pass++;
  endtask

  task automatic test_cursor();
    init_board();
    exp_q.delete();
    cursor_en = 1'b1; cursor_x = 3'd2; cursor_y = 3'd5;
    push_expected(1'b1, 2, 5);
    run_draw(0, 1, 0, 0);
    cursor_en = 1'b0;
    n_chk++; if (fb[35][74] !== 3'b100) $display("FAIL cursor_corner_tl got %b want 100", fb[35][74]); else n_pass++;
    n_chk++; if (fb[46][85] !== 3'b100) $display("FAIL cursor_corner_br got %b want 100", fb[46][85]); else n_pass++;
    n_chk++; if (fb[40][79] !== 3'b010) $display("FAIL cursor_interior got %b want 010", fb[40][79]); else n_pass++;
    n_chk++; if (fb[9][9] !== 3'b010 || fb[20][9] !== 3'b010)
      $display("FAIL cursor_moved got %b/%b want 010/010", fb[9][9], fb[20][9]); else n_pass++;
    n_chk++; if (stream_err !== 0 || exp_q.size() != 0)
      $display("FAIL cursor_stream errs %0d left %0d got %h want %h", stream_err, exp_q.size(), first_got, first_exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    init_board();
    exp_q.delete();
    push_expected(1'b0, 0, 0);
    run_draw(100, 0, 0, 0);
    n_chk++; if (busy_low !== 0) $display("FAIL b2b_busy_low got %0d want 0", busy_low); else n_pass++;
    n_chk++; if (plot_cnt !== 9216) $display("FAIL b2b_plot_count got %0d want 9216", plot_cnt); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL b2b_done_count got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (lat !== 9281) $display("FAIL b2b_done_latency got %0d want 9281", lat); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    int held;
    init_board();
    exp_q.delete();
    push_expected(1'b0, 0, 0);
    run_draw(0, 0, 0, 5000);
    n_chk++; if ({rst_plot, rst_busy} !== 2'b00) $display("FAIL midrst_ctrl got %b want 00", {rst_plot, rst_busy}); else n_pass++;
    held = plot_cnt;
    repeat (5) @(negedge clock);
    n_chk++; if (plot_cnt !== held || busy !== 1'b0)
      $display("FAIL midrst_idle plots %0d want %0d busy %b", plot_cnt, held, busy); else n_pass++;
    exp_q.delete();
    push_expected(1'b0, 0, 0);
    run_draw(0, 0, 0, 0);
    n_chk++; if (plot_cnt !== 9216) $display("FAIL midrst_redraw_count got %0d want 9216", plot_cnt); else n_pass++;
    n_chk++; if (stream_err !== 0 || exp_q.size() != 0)
      $display("FAIL midrst_stream errs %0d left %0d got %h want %h", stream_err, exp_q.size(), first_got, first_exp); else n_pass++;
  endtask

  // Cell (0,4) draws during cycles 4641..4784; the board changes at 4700.
  task automatic test_board_update();
    init_board();
    exp_q.delete();
    mboard[7][7] = 2'b11;
    push_expected(1'b0, 0, 0);
    run_draw(0, 0, 4700, 0);
    n_chk++; if (fb[105][105] !== 3'b111) $display("FAIL upd_last_cell got %b want 111", fb[105][105]); else n_pass++;
    n_chk++; if (fb[9][9] !== 3'b010 || fb[48][48] !== 3'b000)
      $display("FAIL upd_early_cells got %b/%b want 010/000", fb[9][9], fb[48][48]); else n_pass++;
    n_chk++; if (stream_err !== 0 || exp_q.size() != 0)
      $display("FAIL upd_stream errs %0d left %0d got %h want %h", stream_err, exp_q.size(), first_got, first_exp); else n_pass++;
    init_board();
  endtask

  initial begin
    init_board();
    test_reset();
    test_initial_board();
    test_cursor();
    test_back_to_back();
    test_reset_mid_draw();
    test_board_update();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
